// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Defines the FSM state encoding, memory-control bit positions and the load-use match rule.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LB2    = 2'd1,
    ST_FREEZE = 2'd2
  } hz_state_e;

  localparam int MEMREAD   = 1;
  localparam int MEMWRITE  = 0;
  localparam int CNT_W_DEF = 16;
  localparam int REG_W     = 5;

  // A load in ID/EX whose destination feeds the instruction now in IF/ID.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] idex_rt,
    input logic [REG_W-1:0] ifid_rs,
    input logic [REG_W-1:0] ifid_rt,
    input logic             uses_rt
  );
    logic dst_valid;
    logic rs_match;
    logic rt_match;
    dst_valid = (idex_rt != 5'd0);
    rs_match  = (idex_rt == ifid_rs);
    rt_match  = uses_rt & (idex_rt == ifid_rt);
    return mem_read & dst_valid & (rs_match | rt_match);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-register taps, stall/flush controls and counters.
// The slave side is the hazard controller; the master side is the surrounding pipeline.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [1:0]       idex_m_i;
  logic [4:0]       idex_rt_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             ifid_branch_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             clr_cnt_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [1:0]       state_o;

  modport slave (
    input  idex_m_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           ifid_branch_i, branch_taken_i, mem_busy_i, clr_cnt_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_bubble_o, stall_cnt_o, flush_cnt_o, state_o
  );

  modport master (
    output idex_m_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           ifid_branch_i, branch_taken_i, mem_busy_i, clr_cnt_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_bubble_o, stall_cnt_o, flush_cnt_o, state_o
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence over counting.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_r;
  logic         at_max_s;

  assign at_max_s = (cnt_r == {W{1'b1}});

  // Count register: clear, else increment until all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= {W{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {W{1'b0}};
    end else if (en_i && !at_max_s) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and load-to-branch
// stalls, taken-branch IF/ID flush, and whole-pipe freeze while data memory is busy.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave bus
);

  hz_state_e state_r;
  hz_state_e state_nxt_s;
  hz_state_e eff_state_s;
  logic      resume_r;
  logic      resume_nxt_s;
  logic      hit_s;
  logic      pc_write_s;
  logic      ifid_write_s;
  logic      ifid_flush_s;
  logic      idex_write_s;
  logic      idex_bubble_s;
  logic      stall_en_s;
  logic      unused_memwrite_s;
  logic [CNT_W-1:0] stall_cnt_s;
  logic [CNT_W-1:0] flush_cnt_s;

  assign unused_memwrite_s = bus.idex_m_i[MEMWRITE];

  assign hit_s = load_use_hit(bus.idex_m_i[MEMREAD], bus.idex_rt_i,
                              bus.ifid_rs_i, bus.ifid_rt_i, bus.ifid_uses_rt_i);

  // State and resume registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_RUN;
      resume_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      resume_r <= resume_nxt_s;
    end
  end

  // Next-state and control decode. Once busy drops, the FREEZE state acts
  // immediately as the state it interrupted, so no extra cycle is lost on exit.
  always_comb begin
    state_nxt_s   = state_r;
    resume_nxt_s  = resume_r;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_write_s  = 1'b1;
    idex_bubble_s = 1'b0;

    if (state_r == ST_FREEZE) begin
      eff_state_s = resume_r ? ST_LB2 : ST_RUN;
    end else begin
      eff_state_s = state_r;
    end

    if (bus.mem_busy_i) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      idex_write_s = 1'b0;
      state_nxt_s  = ST_FREEZE;
      if (state_r != ST_FREEZE) begin
        resume_nxt_s = (state_r == ST_LB2);
      end else begin
        resume_nxt_s = resume_r;
      end
    end else begin
      case (eff_state_s)
        ST_LB2: begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_bubble_s = 1'b1;
          state_nxt_s   = ST_RUN;
        end
        ST_RUN: begin
          if (hit_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            state_nxt_s   = bus.ifid_branch_i ? ST_LB2 : ST_RUN;
          end else if (bus.branch_taken_i) begin
            ifid_flush_s = 1'b1;
            state_nxt_s  = ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  assign stall_en_s = ~pc_write_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_en_s),
    .clr_i (bus.clr_cnt_i),
    .cnt_o (stall_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (ifid_flush_s),
    .clr_i (bus.clr_cnt_i),
    .cnt_o (flush_cnt_s)
  );

  assign bus.pc_write_o    = pc_write_s;
  assign bus.ifid_write_o  = ifid_write_s;
  assign bus.ifid_flush_o  = ifid_flush_s;
  assign bus.idex_write_o  = idex_write_s;
  assign bus.idex_bubble_o = idex_bubble_s;
  assign bus.stall_cnt_o   = stall_cnt_s;
  assign bus.flush_cnt_o   = flush_cnt_s;
  assign bus.state_o       = state_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic,
// compared against a stall-bookkeeping reference model.
module tb_hazard_ctrl;

  localparam int TW   = 4;
  localparam int CMAX = 15;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_if #(.CNT_W(TW)) bus ();

  hazard_ctrl #(.CNT_W(TW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: is the pipe frozen, is a second branch stall still owed, counter values.
  bit m_frozen = 1'b0;
  bit m_owed   = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic drive(input int m, input int rt, input int rs, input int irt, input int uses,
                       input int br, input int taken, input int busy, input int clr);
    bus.idex_m_i       = 2'(m);
    bus.idex_rt_i      = 5'(rt);
    bus.ifid_rs_i      = 5'(rs);
    bus.ifid_rt_i      = 5'(irt);
    bus.ifid_uses_rt_i = 1'(uses);
    bus.ifid_branch_i  = 1'(br);
    bus.branch_taken_i = 1'(taken);
    bus.mem_busy_i     = 1'(busy);
    bus.clr_cnt_i      = 1'(clr);
  endtask

  task automatic idle(input int clr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, clr);
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic cycle_chk();
    bit hit;
    bit pcw, ifw, fl, idw, bub, nxt_owed;
    int exp_state;
    #2;
    hit = bus.idex_m_i[1] && (bus.idex_rt_i != 5'd0) &&
          ((bus.idex_rt_i == bus.ifid_rs_i) ||
           (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));
    exp_state = m_frozen ? 2 : (m_owed ? 1 : 0);
    pcw = 1'b1; ifw = 1'b1; fl = 1'b0; idw = 1'b1; bub = 1'b0;
    nxt_owed = m_owed;
    if (bus.mem_busy_i) begin
      pcw = 1'b0; ifw = 1'b0; idw = 1'b0;
    end else if (m_owed) begin
      pcw = 1'b0; ifw = 1'b0; bub = 1'b1; nxt_owed = 1'b0;
    end else if (hit) begin
      pcw = 1'b0; ifw = 1'b0; bub = 1'b1; nxt_owed = bus.ifid_branch_i;
    end else if (bus.branch_taken_i) begin
      fl = 1'b1;
    end
    check_val("ctl", int'({bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                           bus.idex_write_o, bus.idex_bubble_o}),
              int'({pcw, ifw, fl, idw, bub}));
    check_val("state", int'(bus.state_o), exp_state);
    check_val("stall_cnt", int'(bus.stall_cnt_o), m_stall);
    check_val("flush_cnt", int'(bus.flush_cnt_o), m_flush);
    m_frozen = bus.mem_busy_i;
    m_owed   = nxt_owed;
    if (bus.clr_cnt_i) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!pcw && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    m_frozen = 1'b0;
    m_owed   = 1'b0;
    m_stall  = 0;
    m_flush  = 0;
  endtask

  initial begin
    idle(0);
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_state", int'(bus.state_o), 0);
    check_val("rst_ctl", int'({bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                               bus.idex_write_o, bus.idex_bubble_o}), 5'b11010);
    check_val("rst_stall", int'(bus.stall_cnt_o), 0);
    check_val("rst_flush", int'(bus.flush_cnt_o), 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Load-use: lw $5 followed by add using $5.
    idle(1); cycle_chk();
    drive(2, 5, 5, 9, 1, 0, 0, 0, 0); cycle_chk();
    idle(0); cycle_chk();
    check_val("lu_stall_cnt", int'(bus.stall_cnt_o), 1);

    // Load-to-branch: lw $8 then beq on $8 -> two stalls, RUN->LB2->RUN.
    idle(1); cycle_chk();
    drive(2, 8, 8, 0, 1, 1, 0, 0, 0); cycle_chk();
    drive(0, 0, 8, 0, 1, 1, 0, 0, 0); cycle_chk();
    idle(0); cycle_chk();
    check_val("lb_stall_cnt", int'(bus.stall_cnt_o), 2);

    // No false hits: $0 destination, rt match without rt use or without MemRead.
    idle(1); cycle_chk();
    drive(2, 0, 0, 0, 1, 0, 0, 0, 0); cycle_chk();
    drive(1, 7, 3, 7, 0, 0, 0, 0, 0); cycle_chk();
    drive(2, 7, 3, 7, 0, 0, 0, 0, 0); cycle_chk();
    drive(1, 7, 3, 7, 1, 0, 0, 0, 0); cycle_chk();
    check_val("nohit_stall_cnt", int'(bus.stall_cnt_o), 0);

    // Taken branch flushes once; with a hit it stalls instead.
    idle(1); cycle_chk();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); cycle_chk();
    idle(0); cycle_chk();
    check_val("tb_flush_cnt", int'(bus.flush_cnt_o), 1);
    drive(2, 4, 4, 0, 0, 0, 1, 0, 0); cycle_chk();
    idle(0); cycle_chk();
    check_val("tb_hit_flush_cnt", int'(bus.flush_cnt_o), 1);
    check_val("tb_hit_stall_cnt", int'(bus.stall_cnt_o), 1);

    // Freeze during LB2: 1 + 3 frozen + 1 remaining LB2 stall = 5.
    idle(1); cycle_chk();
    drive(2, 8, 8, 0, 1, 1, 0, 0, 0); cycle_chk();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8, 0, 1, 1, 1, 1, 0); cycle_chk();
    end
    drive(0, 0, 8, 0, 1, 1, 1, 0, 0); cycle_chk();
    idle(0); cycle_chk();
    check_val("frz_stall_cnt", int'(bus.stall_cnt_o), 5);

    // Saturation, then clear winning over a concurrent stall.
    idle(1); cycle_chk();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle_chk();
    end
    check_val("sat_stall_cnt", int'(bus.stall_cnt_o), 15);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); cycle_chk();
    check_val("clr_stall_cnt", int'(bus.stall_cnt_o), 0);

    // Async reset mid-FREEZE takes effect without a clock edge.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle_chk();
    #1;
    rst_i = 1'b0;
    #1;
    check_val("arst_frz_state", int'(bus.state_o), 0);
    check_val("arst_frz_stall", int'(bus.stall_cnt_o), 0);
    idle(0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();

    // Async reset mid-LB2.
    drive(2, 8, 8, 0, 1, 1, 0, 0, 0); cycle_chk();
    #1;
    rst_i = 1'b0;
    #1;
    check_val("arst_lb2_state", int'(bus.state_o), 0);
    idle(0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 5) == 0) ? 1 : 0,
            ($urandom_range(0, 15) == 0) ? 1 : 0);
      cycle_chk();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It consumes the ID/EX register's outputs (load flag, `rt`) and the IF/ID instruction's source registers, and drives the write-enable and bubble/flush controls back into PC, IF/ID and ID/EX. It handles three cases: load-use stalls, two-cycle load-to-branch stalls (branches resolve in ID), and whole-pipe freezes while data memory is busy. It also keeps saturating stall and flush counters for performance analysis.

## Interface
- `CNT_W`, 16, width of performance counters
- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `idex_m_i`  in  2  ID/EX memory control; bit1 = MemRead, bit0 = MemWrite
- `idex_rt_i`  in  5  ID/EX `rt` (load destination)
- `ifid_rs_i`  in  5  IF/ID instruction `rs`
- `ifid_rt_i`  in  5  IF/ID instruction `rt`
- `ifid_uses_rt_i`  in  1  ID instruction reads `rt` as a source (R-type, beq, sw)
- `ifid_branch_i`  in  1  ID instruction is a branch (operands compared in ID)
- `branch_taken_i`  in  1  ID branch/jump resolved taken this cycle
- `mem_busy_i`  in  1  data memory not ready; freeze pipe
- `clr_cnt_i`  in  1  synchronous clear of both counters
- `pc_write_o`  out  1  PC load enable
- `ifid_write_o`  out  1  IF/ID load enable
- `ifid_flush_o`  out  1  IF/ID loads a NOP
- `idex_write_o`  out  1  ID/EX load enable
- `idex_bubble_o`  out  1  ID/EX loads zero WB/M/EX controls
- `stall_cnt_o`  out  CNT_W  stall cycles, saturating
- `flush_cnt_o`  out  CNT_W  flushes, saturating
- `state_o`  out  2  current FSM state

## Operation
- Hazard match `hit` = MemRead(`idex_m_i[1]`) & `idex_rt_i`≠0 & (`idex_rt_i`==`ifid_rs_i` | (`ifid_uses_rt_i` & `idex_rt_i`==`ifid_rt_i`)).
- States: RUN(0), LB2(1) second load-to-branch stall, FREEZE(2).
- Priority each cycle: `mem_busy_i` > forced LB2 stall > `hit` > `branch_taken_i`.
- FREEZE behaviour (entered/held whenever `mem_busy_i`=1): pc/ifid/idex write = 0, no flush, no bubble. On exit, return to the state saved at entry (RUN or LB2) via a 1-bit `resume` register.
- LB2: pc_write=0, ifid_write=0, idex_bubble=1. Next state is RUN unless busy.
- RUN with `hit`: pc_write=0, ifid_write=0, idex_bubble=1. Next state is LB2 if `ifid_branch_i`, else RUN.
- RUN without hazard and with `branch_taken_i`: ifid_flush=1, all writes=1.
- Otherwise all writes=1, flush=0, bubble=0.
- `branch_taken_i` is ignored during any stall cycle. The branch re-resolves once operands are valid.
- `stall_cnt_o` +1 per cycle with pc_write=0 (FREEZE included). `flush_cnt_o` +1 per flush cycle. Both saturate at all-ones. `clr_cnt_i` wins over increment.
- idex_write_o stays 1 during bubbles; the bubble is written, not held.

## Timing
- Control outputs are combinational from state and inputs (same-cycle). Counters and state are registered.
- Reset: state=RUN, resume=RUN, counters=0. With `mem_busy_i`=0 and no hazard, outputs are pc/ifid/idex write=1, flush=0, bubble=0.
- Load-use: exactly 1 stall cycle. Load-to-branch: exactly 2 consecutive stall cycles.
- Reset asserted mid-LB2 or mid-FREEZE: immediate return to RUN; counters cleared.
- `mem_busy_i` rising in LB2 freezes the pipe; the remaining LB2 stall completes after busy drops.
- `idex_rt_i`=0 never stalls.

## Structure
- Package `pipe_pkg`: state enum, M/WB bit indices (MEMREAD=1, MEMWRITE=0), `CNT_W` default.
- Sub-module `sat_counter` (enable, sync clear, width param), instantiated twice.

## Test plan
- Load-use: ID/EX `lw $5` (M=2'b10, rt=5), IF/ID `add` rs=5 -> 1 cycle pc_write=0, bubble=1; stall_cnt=1.
- Load-to-branch: ID/EX `lw $8`, IF/ID `beq` rs=8 branch=1 -> 2 stall cycles, state RUN→LB2→RUN; stall_cnt=2.
- No false hit: `lw $0` with rs=0, then `sw` rt match with uses_rt=0 and MemRead=0 -> no stall.
- Taken branch: branch_taken=1, no hazard -> ifid_flush=1 one cycle; flush_cnt=1. Same with hit=1 -> stall, no flush.
- Freeze in LB2: mem_busy=1 for 3 cycles during LB2 -> writes=0 for those 3 cycles, then 1 LB2 cycle; stall_cnt=5.
- Saturation/clear: CNT_W=4, 20 stall cycles -> stall_cnt=15. clr_cnt_i with concurrent stall -> 0. Async reset mid-FREEZE -> state_o=0 immediately.
